f_fetch_unit: RTL and testbench

- Fetch (F) stage of the 5-stage MIPS pipeline; feeds the F/D pipeline register.
- Owns the program counter and computes the next PC from sequential, branch/jump, exception-entry and ERET sources.
- Drives the instruction-memory address and produces F_pc, F_instr, F_exc and F_bd for the D stage.
- Detects fetch address errors (AdEL) and tracks handler mode plus a retired-fetch counter for debug.

---
 rtl/f_fetch_unit_pkg.sv | 32 +++
 rtl/f_fetch_unit_if.sv | 36 +++
 rtl/f_fetch_unit_npc_sel.sv | 37 +++
 rtl/f_fetch_unit.sv | 100 ++++++++++
 tb/tb_f_fetch_unit.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/f_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// mips_defs : constants and types shared by the F stage and its neighbours.
//   - CP0 exception codes (EXC_*)
//   - fetch address map (PC_RESET, EXC_ENTRY, TEXT_LO, TEXT_HI)
//   - handler-mode state enum
//   - fetch_addr_err(): fetch address error (AdEL) predicate
// -----------------------------------------------------------------------------
package mips_defs;

   localparam logic [4:0]  EXC_NONE  = 5'd0;
   localparam logic [4:0]  EXC_INT   = 5'd0;
   localparam logic [4:0]  EXC_ADEL  = 5'd4;
   localparam logic [4:0]  EXC_ADES  = 5'd5;
   localparam logic [4:0]  EXC_RI    = 5'd10;
   localparam logic [4:0]  EXC_OV    = 5'd12;

   localparam logic [31:0] PC_RESET  = 32'h0000_3000;
   localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
   localparam logic [31:0] TEXT_LO   = 32'h0000_3000;
   localparam logic [31:0] TEXT_HI   = 32'h0000_6FFC;

   typedef enum logic {
      ST_NORMAL  = 1'b0,
      ST_HANDLER = 1'b1
   } handler_state_e;

   // A fetch is illegal when misaligned or outside the text segment.
   function automatic logic fetch_addr_err(input logic [31:0] addr);
      return (addr[1:0] != 2'b00) || (addr < TEXT_LO) || (addr > TEXT_HI);
   endfunction

endpackage

// File: rtl/f_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// f_fetch_unit_if : instruction-memory bus plus the F/D stage outputs.
//   imem_addr  : fetch address to instruction memory
//   imem_rdata : instruction word at imem_addr (combinational read)
//   F_pc, F_instr, F_exc, F_bd : fetched instruction bundle for the D stage
// modport master : the fetch unit (drives address and F/D bundle)
// modport slave  : memory / D stage side (returns the instruction word)
// -----------------------------------------------------------------------------
interface f_fetch_unit_if;

   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] F_pc;
   logic [31:0] F_instr;
   logic [4:0]  F_exc;
   logic        F_bd;

   modport master (
      output imem_addr,
      input  imem_rdata,
      output F_pc,
      output F_instr,
      output F_exc,
      output F_bd
   );

   modport slave (
      input  imem_addr,
      output imem_rdata,
      input  F_pc,
      input  F_instr,
      input  F_exc,
      input  F_bd
   );

endinterface

// File: rtl/f_fetch_unit_npc_sel.sv
// -----------------------------------------------------------------------------
// f_npc_sel : combinational next-PC priority mux.
//   Priority: req (exception entry) > eret (to epc) > D redirect > pc+4 > hold.
//   Ports: pc, en, req, eret, epc, d_redirect, d_target in; npc out.
// -----------------------------------------------------------------------------
module f_npc_sel
   import mips_defs::*;
(
   input  logic [31:0] pc,
   input  logic        en,
   input  logic        req,
   input  logic        eret,
   input  logic [31:0] epc,
   input  logic        d_redirect,
   input  logic [31:0] d_target,
   output logic [31:0] npc
);

   // Next-PC selection; req overrides a stall, everything else waits for en.
   always_comb begin
      npc = pc;
      if (req) begin
         npc = EXC_ENTRY;
      end else if (en) begin
         if (eret) begin
            npc = epc;
         end else if (d_redirect) begin
            npc = d_target;
         end else begin
            npc = pc + 32'd4;   // wraps mod 2^32
         end
      end else begin
         npc = pc;
      end
   end

endmodule

// File: rtl/f_fetch_unit.sv
// -----------------------------------------------------------------------------
// f_fetch_unit : F stage of the 5-stage MIPS pipeline.
//   clk, reset       : clock, asynchronous active-high reset
//   en               : 1 = advance PC, 0 = stall
//   req              : CP0 exception/interrupt request (flush + redirect)
//   eret, epc        : ERET in D and the CP0 EPC it returns to
//   d_redirect       : D-stage branch taken / jump, target on d_target
//   d_is_cti         : D holds a branch/jump, so F holds its delay slot
//   bus (master)     : imem_addr/imem_rdata and F_pc/F_instr/F_exc/F_bd
//   in_handler       : 1 between exception entry and ERET
//   fetch_cnt        : fetches accepted by the pipeline (debug)
// -----------------------------------------------------------------------------
module f_fetch_unit
   import mips_defs::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  req,
   input  logic                  eret,
   input  logic [31:0]           epc,
   input  logic                  d_redirect,
   input  logic [31:0]           d_target,
   input  logic                  d_is_cti,
   f_fetch_unit_if.master        bus,
   output logic                  in_handler,
   output logic [31:0]           fetch_cnt
);

   logic [31:0]    pc_r;
   logic [31:0]    npc_s;
   logic           adel_s;
   handler_state_e state_r;
   logic [31:0]    fetch_cnt_r;

   f_npc_sel u_npc_sel (
      .pc         (pc_r),
      .en         (en),
      .req        (req),
      .eret       (eret),
      .epc        (epc),
      .d_redirect (d_redirect),
      .d_target   (d_target),
      .npc        (npc_s)
   );

   assign adel_s = fetch_addr_err(pc_r);

   // PC register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_r <= PC_RESET;
      end else begin
         pc_r <= npc_s;
      end
   end

   // Handler-mode FSM; a simultaneous req keeps us in HANDLER.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_NORMAL;
      end else begin
         case (state_r)
            ST_NORMAL:  state_r <= req ? ST_HANDLER : ST_NORMAL;
            ST_HANDLER: state_r <= (eret && en && !req) ? ST_NORMAL : ST_HANDLER;
            default:    state_r <= ST_NORMAL;
         endcase
      end
   end

   // Retired-fetch counter: only fetches that really enter the pipeline.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_cnt_r <= 32'd0;
      end else if (en && !req && !adel_s && !eret) begin
         fetch_cnt_r <= fetch_cnt_r + 32'd1;
      end else begin
         fetch_cnt_r <= fetch_cnt_r;
      end
   end

   // F/D bundle. F_pc keeps the real pc even when nullified so EPC capture
   // downstream sees the faulting address; ERET has no delay slot, so the
   // word fetched behind it is dropped and never marked as a delay slot.
   always_comb begin
      bus.imem_addr = pc_r;
      bus.F_pc      = pc_r;
      bus.F_exc     = adel_s ? EXC_ADEL : EXC_NONE;
      bus.F_bd      = d_is_cti && !eret;
      if (adel_s || eret || req) begin
         bus.F_instr = 32'd0;
      end else begin
         bus.F_instr = bus.imem_rdata;
      end
   end

   assign in_handler = (state_r == ST_HANDLER);
   assign fetch_cnt  = fetch_cnt_r;

endmodule

// File: tb/tb_f_fetch_unit.sv
module tb_f_fetch_unit;
   import mips_defs::*;

   logic        clk;
   logic        reset;
   logic        en;
   logic        req;
   logic        eret;
   logic [31:0] epc;
   logic        d_redirect;
   logic [31:0] d_target;
   logic        d_is_cti;
   logic        in_handler;
   logic [31:0] fetch_cnt;

   f_fetch_unit_if bus ();

   f_fetch_unit dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .req        (req),
      .eret       (eret),
      .epc        (epc),
      .d_redirect (d_redirect),
      .d_target   (d_target),
      .d_is_cti   (d_is_cti),
      .bus        (bus.master),
      .in_handler (in_handler),
      .fetch_cnt  (fetch_cnt)
   );

   // Instruction memory model: a recognisable word derived from the address.
   function automatic logic [31:0] imem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   assign bus.imem_rdata = imem_word(bus.imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  exc;
      logic        bd;
      logic        inh;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pop one expectation and compare it against the live DUT outputs.
   task automatic compare_head();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty: observed=0 expected=1");
      end else begin
         e = sb.pop_front();
         chk({e.tag, ".F_pc"},       bus.F_pc,            e.pc);
         chk({e.tag, ".imem_addr"},  bus.imem_addr,       e.pc);
         chk({e.tag, ".F_instr"},    bus.F_instr,         e.instr);
         chk({e.tag, ".F_exc"},      {27'd0, bus.F_exc},  {27'd0, e.exc});
         chk({e.tag, ".F_bd"},       {31'd0, bus.F_bd},   {31'd0, e.bd});
         chk({e.tag, ".in_handler"}, {31'd0, in_handler}, {31'd0, e.inh});
         chk({e.tag, ".fetch_cnt"},  fetch_cnt,           e.cnt);
      end
   endtask

   // Push the expectation for the current cycle (instruction derived from the
   // expected pc unless nullified).
   task automatic expect_out(input string tag, input logic [31:0] pc, input logic nul,
                             input logic [4:0] exc, input logic bd, input logic inh,
                             input logic [31:0] cnt);
      exp_t e;
      e.tag   = tag;
      e.pc    = pc;
      e.instr = nul ? 32'd0 : imem_word(pc);
      e.exc   = exc;
      e.bd    = bd;
      e.inh   = inh;
      e.cnt   = cnt;
      sb.push_back(e);
   endtask

   // One cycle: drive inputs, push expectation, compare, then clock.
   task automatic step(input string tag,
                       input logic i_en, input logic i_req, input logic i_eret,
                       input logic [31:0] i_epc, input logic i_red,
                       input logic [31:0] i_tgt, input logic i_cti,
                       input logic [31:0] x_pc, input logic x_nul, input logic [4:0] x_exc,
                       input logic x_bd, input logic x_inh, input logic [31:0] x_cnt);
      en = i_en; req = i_req; eret = i_eret; epc = i_epc;
      d_redirect = i_red; d_target = i_tgt; d_is_cti = i_cti;
      expect_out(tag, x_pc, x_nul, x_exc, x_bd, x_inh, x_cnt);
      #1;
      compare_head();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; req = 1'b0; eret = 1'b0; epc = 32'd0;
      d_redirect = 1'b0; d_target = 32'd0; d_is_cti = 1'b0;
      #12;
      expect_out("reset", 32'h3000, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
      compare_head();
      @(posedge clk); #1;
      reset = 1'b0;

      //    tag       en   req  eret epc           red  tgt           cti   pc            nul  exc    bd   inh  cnt
      step("seq0",   1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0, 32'h3000,     1'b0,5'd0,  1'b0,1'b0,32'd0);
      step("seq1",   1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0, 32'h3004,     1'b0,5'd0,  1'b0,1'b0,32'd1);
      step("seq2",   1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0, 32'h3008,     1'b0,5'd0,  1'b0,1'b0,32'd2);
      step("seq3",   1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0, 32'h300C,     1'b0,5'd0,  1'b0,1'b0,32'd3);
      step("stall0", 1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0, 32'h3010,     1'b0,5'd0,  1'b0,1'b0,32'd4);
      step("stall1", 1'b0,1'b0,1'b0,32'h0,        1'b1,32'h3200,     1'b0, 32'h3010,     1'b0,5'd0,  1'b0,1'b0,32'd4);
      step("stall2", 1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0, 32'h3010,     1'b0,5'd0,  1'b0,1'b0,32'd4);
      step("req_st", 1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0, 32'h3010,     1'b1,5'd0,  1'b0,1'b0,32'd4);
      step("hnd0",   1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0, 32'h4180,     1'b0,5'd0,  1'b0,1'b1,32'd4);
      step("eret",   1'b1,1'b0,1'b1,32'h3024,     1'b0,32'h0,        1'b1, 32'h4184,     1'b1,5'd0,  1'b0,1'b1,32'd5);
      step("ret0",   1'b1,1'b0,1'b0,32'h0,        1'b1,32'h3008,     1'b0, 32'h3024,     1'b0,5'd0,  1'b0,1'b0,32'd5);
      step("cti",    1'b1,1'b0,1'b0,32'h0,        1'b1,32'h3100,     1'b1, 32'h3008,     1'b0,5'd0,  1'b1,1'b0,32'd6);
      step("tgt",    1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0, 32'h3100,     1'b0,5'd0,  1'b0,1'b0,32'd7);
      step("req_en", 1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0, 32'h3104,     1'b1,5'd0,  1'b0,1'b0,32'd8);
      step("req_er", 1'b1,1'b1,1'b1,32'h3024,     1'b0,32'h0,        1'b0, 32'h4180,     1'b1,5'd0,  1'b0,1'b1,32'd8);
      step("eret2",  1'b1,1'b0,1'b1,32'h3020,     1'b0,32'h0,        1'b0, 32'h4180,     1'b1,5'd0,  1'b0,1'b1,32'd8);
      step("ret1",   1'b1,1'b0,1'b0,32'h0,        1'b1,32'h3002,     1'b0, 32'h3020,     1'b0,5'd0,  1'b0,1'b0,32'd8);
      step("mis",    1'b1,1'b0,1'b0,32'h0,        1'b1,32'h7000,     1'b0, 32'h3002,     1'b1,5'd4,  1'b0,1'b0,32'd9);
      step("hi_out", 1'b1,1'b0,1'b0,32'h0,        1'b1,32'h6FFC,     1'b0, 32'h7000,     1'b1,5'd4,  1'b0,1'b0,32'd9);
      step("hi_in",  1'b1,1'b0,1'b0,32'h0,        1'b1,32'h2FFC,     1'b0, 32'h6FFC,     1'b0,5'd0,  1'b0,1'b0,32'd9);
      step("lo_out", 1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0, 32'h2FFC,     1'b1,5'd4,  1'b0,1'b0,32'd10);
      step("hnd1",   1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0, 32'h4180,     1'b0,5'd0,  1'b0,1'b1,32'd10);

      // Asynchronous reset between edges while redirecting at 0x4184.
      en = 1'b1; d_redirect = 1'b1; d_target = 32'h3300;
      expect_out("pre_rst", 32'h4184, 1'b0, 5'd0, 1'b0, 1'b1, 32'd11);
      #1;
      compare_head();
      #1;
      reset = 1'b1;
      expect_out("async_rst", 32'h3000, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
      #1;
      compare_head();
      #2;
      reset = 1'b0;
      d_redirect = 1'b0;
      #1;
      @(posedge clk); #1;
      step("post0",  1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0, 32'h3004,     1'b0,5'd0,  1'b0,1'b0,32'd1);
      step("post1",  1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0, 32'h3008,     1'b0,5'd0,  1'b0,1'b0,32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
